mc_control_unit: RTL and testbench

MC_CONTROL_UNIT -- requirements
Module: mc_control_unit

---
 rtl/mc_ctrl_pkg.sv | 41 ++++
 rtl/mc_aluop_decode.sv | 26 ++
 rtl/mc_control_unit.sv | 219 +++++++++++++++++++++
 tb/tb_mc_control_unit.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared constants for the multi-cycle control unit: state codes,
// opcode / funct values the decoder recognises, and fixed ALU operations.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_RTYPE    = 4'd2,
    ST_RITYPE   = 4'd3,
    ST_RTYPEEND = 4'd4,
    ST_LW1      = 4'd5,
    ST_LW2      = 4'd6,
    ST_SW       = 4'd7,
    ST_JALR     = 4'd8,
    ST_BRANCH   = 4'd9,
    ST_BRANCH2  = 4'd10,
    ST_JAL      = 4'd11,
    ST_HALT     = 4'd12
  } state_e;

  // Opcode field values
  localparam int unsigned OP_RTYPE  = 0;
  localparam int unsigned OP_ITYPE  = 1;  // immediate ALU, JALR or branch by funct
  localparam int unsigned OP_ITYPE2 = 2;  // immediate ALU, load or store by funct
  localparam int unsigned OP_NOP    = 3;
  localparam int unsigned OP_JAL    = 4;

  // Funct field values with control meaning
  localparam int unsigned FN_PASS_MAX = 8;
  localparam int unsigned FN_LW       = 9;
  localparam int unsigned FN_SW       = 10;
  localparam int unsigned FN_JALR     = 11;
  localparam int unsigned FN_BR_LO    = 12;
  localparam int unsigned FN_BR_HI    = 15;

  // Fixed ALU operations
  localparam int unsigned ALU_ADD  = 0;
  localparam int unsigned ALU_SUB  = 1;
  localparam int unsigned ALU_LINK = 12;

endpackage

// File: rtl/mc_aluop_decode.sv
// Maps the IR funct field onto an ALU operation for R / RI type execution.
module mc_aluop_decode
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned FUNCT_W = 4,
  parameter int unsigned ALUOP_W = 4
) (
  input  logic [FUNCT_W-1:0] funct_i,
  output logic [ALUOP_W-1:0] aluop_o
);

  logic [31:0] funct_w;

  assign funct_w = 32'(funct_i);

  // Low funct values name an ALU op directly; 12 selects the link op; rest add.
  always_comb begin
    aluop_o = '0;
    if (funct_w <= FN_PASS_MAX) begin
      aluop_o = ALUOP_W'(funct_w);
    end else if (funct_w == ALU_LINK) begin
      aluop_o = ALUOP_W'(ALU_LINK);
    end
  end

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle processor control FSM with memory handshake, stall freeze,
// sticky illegal-opcode flag and retired-instruction counter.
module mc_control_unit
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned OPC_W   = 3,
  parameter int unsigned FUNCT_W = 4,
  parameter int unsigned ALUOP_W = 4,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic [OPC_W-1:0]   opcode,
  input  logic [FUNCT_W-1:0] funct,
  input  logic               mem_ready,
  input  logic               stall,
  output logic               mem_req,
  output logic               Branch,
  output logic               IoD,
  output logic               IRWrite,
  output logic               Mem2Reg,
  output logic               MemR,
  output logic               MemW,
  output logic               PCSrc,
  output logic               PCWrite,
  output logic               RegWrite,
  output logic               keepALUOut,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         BranchType,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic [3:0]         state,
  output logic               illegal,
  output logic               instr_retired,
  output logic [CNT_W-1:0]   retired_count
);

  state_e             state_q, state_d;
  logic               illegal_q;
  logic [CNT_W-1:0]   count_q;
  logic               retire;
  logic [ALUOP_W-1:0] alu_dec;
  logic [31:0]        opc_w;
  logic [31:0]        funct_w;

  assign opc_w   = 32'(opcode);
  assign funct_w = 32'(funct);

  mc_aluop_decode #(
    .FUNCT_W (FUNCT_W),
    .ALUOP_W (ALUOP_W)
  ) u_aluop_decode (
    .funct_i (funct),
    .aluop_o (alu_dec)
  );

  // Next state, per-state datapath controls, then the stall freeze on top.
  always_comb begin
    state_d    = state_q;
    retire     = 1'b0;
    mem_req    = 1'b0;
    Branch     = 1'b0;
    IoD        = 1'b0;
    IRWrite    = 1'b0;
    Mem2Reg    = 1'b0;
    MemR       = 1'b0;
    MemW       = 1'b0;
    PCSrc      = 1'b0;
    PCWrite    = 1'b0;
    RegWrite   = 1'b0;
    keepALUOut = 1'b0;
    ALUSrcA    = 2'd0;
    ALUSrcB    = 2'd0;
    BranchType = 2'd0;
    ALUOp      = '0;

    case (state_q)
      ST_FETCH: begin
        MemR    = 1'b1;
        mem_req = 1'b1;
        ALUSrcB = 2'd1;
        ALUOp   = ALUOP_W'(ALU_ADD);
        IRWrite = mem_ready;
        PCWrite = mem_ready;
        if (mem_ready) state_d = ST_DECODE;
      end
      ST_DECODE: begin
        keepALUOut = 1'b1;
        case (opc_w)
          OP_RTYPE: state_d = ST_RTYPE;
          OP_ITYPE: begin
            if (funct_w == FN_JALR)
              state_d = ST_JALR;
            else if (funct_w >= FN_BR_LO && funct_w <= FN_BR_HI)
              state_d = ST_BRANCH;
            else
              state_d = ST_RITYPE;
          end
          OP_ITYPE2: state_d = ST_RITYPE;
          OP_NOP: begin
            state_d = ST_FETCH;
            retire  = 1'b1;
          end
          OP_JAL:  state_d = ST_JAL;
          default: state_d = ST_HALT;
        endcase
      end
      ST_RTYPE: begin
        ALUSrcA = 2'd2;
        ALUOp   = alu_dec;
        state_d = ST_RTYPEEND;
      end
      ST_RITYPE: begin
        ALUSrcA = 2'd2;
        ALUSrcB = 2'd2;
        Branch  = 1'b1;
        ALUOp   = alu_dec;
        if (funct_w == FN_LW)
          state_d = ST_LW1;
        else if (funct_w == FN_SW)
          state_d = ST_SW;
        else
          state_d = ST_RTYPEEND;
      end
      ST_RTYPEEND: begin
        RegWrite = 1'b1;
        retire   = 1'b1;
        state_d  = ST_FETCH;
      end
      ST_LW1: begin
        IoD     = 1'b1;
        MemR    = 1'b1;
        mem_req = 1'b1;
        if (mem_ready) state_d = ST_LW2;
      end
      ST_LW2: begin
        Mem2Reg  = 1'b1;
        RegWrite = 1'b1;
        retire   = 1'b1;
        state_d  = ST_FETCH;
      end
      ST_SW: begin
        IoD     = 1'b1;
        MemW    = 1'b1;
        mem_req = 1'b1;
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_JALR: begin
        ALUSrcA    = 2'd2;
        ALUSrcB    = 2'd2;
        PCWrite    = 1'b1;
        RegWrite   = 1'b1;
        keepALUOut = 1'b1;
        ALUOp      = ALUOP_W'(ALU_ADD);
        retire     = 1'b1;
        state_d    = ST_FETCH;
      end
      ST_BRANCH: begin
        ALUSrcB    = 2'd2;
        Branch     = 1'b1;
        BranchType = funct[1:0];
        ALUOp      = ALUOP_W'(ALU_ADD);
        state_d    = ST_BRANCH2;
      end
      ST_BRANCH2: begin
        ALUSrcA    = 2'd2;
        Branch     = 1'b1;
        BranchType = funct[1:0];
        PCSrc      = 1'b1;
        PCWrite    = 1'b1;
        ALUOp      = ALUOP_W'(ALU_SUB);
        retire     = 1'b1;
        state_d    = ST_FETCH;
      end
      ST_JAL: begin
        ALUSrcB  = 2'd2;
        PCWrite  = 1'b1;
        RegWrite = 1'b1;
        ALUOp    = ALUOP_W'(ALU_LINK);
        retire   = 1'b1;
        state_d  = ST_FETCH;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_FETCH;
    endcase

    // Freeze only applies to legal codes so a corrupted state still recovers.
    if (stall && (state_q <= ST_HALT)) begin
      state_d  = state_q;
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      RegWrite = 1'b0;
      MemW     = 1'b0;
      retire   = 1'b0;
    end
  end

  // State, sticky illegal flag and wrapping retire counter.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q   <= ST_FETCH;
      illegal_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_d == ST_HALT) illegal_q <= 1'b1;
      if (retire) count_q <= count_q + CNT_W'(1);
    end
  end

  assign state         = state_q;
  assign illegal       = illegal_q;
  assign instr_retired = retire & ~Reset;
  assign retired_count = count_q;

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench for the multi-cycle control unit; a second instance with a
// 2-bit counter shares the stimulus to exercise counter wrap.
module tb_mc_control_unit;

  logic       CLK = 1'b0;
  logic       Reset;
  logic [2:0] opcode;
  logic [3:0] funct;
  logic       mem_ready;
  logic       stall;

  logic        mem_req, Branch, IoD, IRWrite, Mem2Reg, MemR, MemW, PCSrc;
  logic        PCWrite, RegWrite, keepALUOut, illegal, instr_retired;
  logic [1:0]  ALUSrcA, ALUSrcB, BranchType;
  logic [3:0]  ALUOp, state;
  logic [15:0] retired_count;

  logic        mem_req_b, Branch_b, IoD_b, IRWrite_b, Mem2Reg_b, MemR_b, MemW_b, PCSrc_b;
  logic        PCWrite_b, RegWrite_b, keepALUOut_b, illegal_b, instr_retired_b;
  logic [1:0]  ALUSrcA_b, ALUSrcB_b, BranchType_b;
  logic [3:0]  ALUOp_b, state_b;
  logic [1:0]  retired_count_b;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 CLK = ~CLK;

  mc_control_unit dut (
    .CLK(CLK), .Reset(Reset), .opcode(opcode), .funct(funct),
    .mem_ready(mem_ready), .stall(stall), .mem_req(mem_req),
    .Branch(Branch), .IoD(IoD), .IRWrite(IRWrite), .Mem2Reg(Mem2Reg),
    .MemR(MemR), .MemW(MemW), .PCSrc(PCSrc), .PCWrite(PCWrite),
    .RegWrite(RegWrite), .keepALUOut(keepALUOut), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .BranchType(BranchType), .ALUOp(ALUOp),
    .state(state), .illegal(illegal), .instr_retired(instr_retired),
    .retired_count(retired_count)
  );

  mc_control_unit #(.CNT_W(2)) dut_b (
    .CLK(CLK), .Reset(Reset), .opcode(opcode), .funct(funct),
    .mem_ready(mem_ready), .stall(stall), .mem_req(mem_req_b),
    .Branch(Branch_b), .IoD(IoD_b), .IRWrite(IRWrite_b), .Mem2Reg(Mem2Reg_b),
    .MemR(MemR_b), .MemW(MemW_b), .PCSrc(PCSrc_b), .PCWrite(PCWrite_b),
    .RegWrite(RegWrite_b), .keepALUOut(keepALUOut_b), .ALUSrcA(ALUSrcA_b),
    .ALUSrcB(ALUSrcB_b), .BranchType(BranchType_b), .ALUOp(ALUOp_b),
    .state(state_b), .illegal(illegal_b), .instr_retired(instr_retired_b),
    .retired_count(retired_count_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; land just after the edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Let combinational outputs follow freshly driven inputs.
  task automatic settle();
    #1;
  endtask

  initial begin
    Reset = 1'b1; opcode = 3'd0; funct = 4'd0; mem_ready = 1'b1; stall = 1'b0;
    tick(); tick();
    Reset = 1'b0; settle();

    // Reset state: FETCH outputs
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    chk("rst_count", 32'(retired_count), 32'd0);
    chk("rst_fetch_memr", {29'd0, MemR, mem_req, IRWrite}, 32'b111);
    chk("rst_fetch_srcb", 32'(ALUSrcB), 32'd1);

    // FETCH waits on memory
    mem_ready = 1'b0; settle();
    chk("fetch_wait_wr", {30'd0, IRWrite, PCWrite}, 32'd0);
    chk("fetch_wait_memr", 32'(MemR), 32'd1);
    tick();
    chk("fetch_wait_hold", 32'(state), 32'd0);
    mem_ready = 1'b1;

    // R-type opcode 0 funct 1
    opcode = 3'd0; funct = 4'd1; settle();
    chk("rt_fetch_pcw", {30'd0, IRWrite, PCWrite}, 32'b11);
    tick();
    chk("rt_decode", 32'(state), 32'd1);
    chk("rt_decode_keep", 32'(keepALUOut), 32'd1);
    tick();
    chk("rt_rtype", 32'(state), 32'd2);
    chk("rt_aluop", 32'(ALUOp), 32'd1);
    chk("rt_srca", 32'(ALUSrcA), 32'd2);
    tick();
    chk("rt_end", 32'(state), 32'd4);
    chk("rt_regwrite", 32'(RegWrite), 32'd1);
    chk("rt_retire", 32'(instr_retired), 32'd1);
    chk("rt_cnt_before", 32'(retired_count), 32'd0);
    tick();
    chk("rt_back_fetch", 32'(state), 32'd0);
    chk("rt_cnt_after", 32'(retired_count), 32'd1);
    chk("rt_no_retire", 32'(instr_retired), 32'd0);

    // Load opcode 2 funct 9, memory slow for 3 cycles in LW1
    opcode = 3'd2; funct = 4'd9;
    tick(); tick();
    chk("lw_ritype", 32'(state), 32'd3);
    chk("lw_ritype_ctl", {27'd0, ALUSrcA, ALUSrcB, Branch}, {27'd0, 2'd2, 2'd2, 1'b1});
    chk("lw_ritype_aluop", 32'(ALUOp), 32'd0);
    tick();
    for (int i = 0; i < 3; i++) begin
      mem_ready = 1'b0; settle();
      chk("lw1_wait_state", 32'(state), 32'd5);
      chk("lw1_wait_ctl", {29'd0, MemR, IoD, mem_req}, 32'b111);
      chk("lw1_wait_retire", 32'(instr_retired), 32'd0);
      tick();
    end
    mem_ready = 1'b1; settle();
    chk("lw1_ready", 32'(state), 32'd5);
    tick();
    chk("lw2_state", 32'(state), 32'd6);
    chk("lw2_ctl", {30'd0, Mem2Reg, RegWrite}, 32'b11);
    tick();
    chk("lw_cnt", 32'(retired_count), 32'd2);

    // Store opcode 2 funct 10, one wait cycle
    funct = 4'd10;
    tick(); tick(); tick();
    mem_ready = 1'b0; settle();
    chk("sw_state", 32'(state), 32'd7);
    chk("sw_memw_wait", {29'd0, MemW, IoD, instr_retired}, 32'b110);
    tick();
    mem_ready = 1'b1; settle();
    chk("sw_memw_done", {30'd0, MemW, instr_retired}, 32'b11);
    tick();
    chk("sw_cnt", 32'(retired_count), 32'd3);

    // Branch opcode 1 funct 14
    opcode = 3'd1; funct = 4'd14;
    tick(); tick();
    chk("br_state", 32'(state), 32'd9);
    chk("br_ctl", {27'd0, ALUSrcB, BranchType, Branch}, {27'd0, 2'd2, 2'd2, 1'b1});
    chk("br_aluop", 32'(ALUOp), 32'd0);
    tick();
    chk("br2_state", 32'(state), 32'd10);
    chk("br2_ctl", {26'd0, BranchType, PCSrc, PCWrite, ALUSrcA}, {26'd0, 2'd2, 1'b1, 1'b1, 2'd2});
    chk("br2_aluop", 32'(ALUOp), 32'd1);
    tick();
    chk("br_cnt", 32'(retired_count), 32'd4);

    // JALR opcode 1 funct 11
    funct = 4'd11;
    tick(); tick();
    chk("jalr_state", 32'(state), 32'd8);
    chk("jalr_ctl", {29'd0, PCWrite, RegWrite, keepALUOut}, 32'b111);
    tick();
    chk("jalr_cnt", 32'(retired_count), 32'd5);

    // JAL opcode 4
    opcode = 3'd4; funct = 4'd0;
    tick(); tick();
    chk("jal_state", 32'(state), 32'd11);
    chk("jal_aluop", 32'(ALUOp), 32'd12);
    chk("jal_srcb", 32'(ALUSrcB), 32'd2);
    tick();
    chk("jal_cnt", 32'(retired_count), 32'd6);

    // Stall in FETCH keeps the memory request, drops writes
    stall = 1'b1; settle();
    chk("stall_fetch", {28'd0, MemR, mem_req, IRWrite, PCWrite}, 32'b1100);
    tick();
    chk("stall_fetch_hold", 32'(state), 32'd0);
    stall = 1'b0;

    // R-type funct 3 with 2-cycle stall in RTYPEEND
    opcode = 3'd0; funct = 4'd3;
    tick(); tick();
    chk("st_aluop", 32'(ALUOp), 32'd3);
    tick();
    for (int i = 0; i < 2; i++) begin
      stall = 1'b1; settle();
      chk("st_hold_state", 32'(state), 32'd4);
      chk("st_hold_ctl", {30'd0, RegWrite, instr_retired}, 32'd0);
      tick();
    end
    chk("st_cnt_held", 32'(retired_count), 32'd6);
    stall = 1'b0; settle();
    chk("st_release", {30'd0, RegWrite, instr_retired}, 32'b11);
    tick();
    chk("st_cnt", 32'(retired_count), 32'd7);

    // Funct 12 decodes to 12, funct 13 decodes to 0
    funct = 4'd12;
    tick(); tick();
    chk("alu_f12", 32'(ALUOp), 32'd12);
    tick(); tick();
    funct = 4'd13;
    tick(); tick();
    chk("alu_f13", 32'(ALUOp), 32'd0);
    tick(); tick();
    chk("alu_cnt", 32'(retired_count), 32'd9);

    // Illegal opcode 7 -> HALT, sticky
    opcode = 3'd7;
    tick(); tick();
    for (int i = 0; i < 10; i++) begin
      chk("halt_state", 32'(state), 32'd12);
      chk("halt_illegal", 32'(illegal), 32'd1);
      chk("halt_quiet", {28'd0, MemR, mem_req, PCWrite, RegWrite}, 32'd0);
      tick();
    end

    // Reset out of HALT wins over stall
    Reset = 1'b1; stall = 1'b1;
    tick();
    Reset = 1'b0; stall = 1'b0; settle();
    chk("halt_rst_state", 32'(state), 32'd0);
    chk("halt_rst_illegal", 32'(illegal), 32'd0);
    chk("halt_rst_count", 32'(retired_count), 32'd0);
    chk("halt_rst_fetch", {30'd0, MemR, mem_req}, 32'b11);

    // Five no-ops: 2-bit counter wraps
    opcode = 3'd3;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("nop_decode_retire", 32'(instr_retired), 32'd1);
      tick();
      chk("nop_state", 32'(state), 32'd0);
      chk("nop_cnt16", 32'(retired_count), 32'(i + 1));
      chk("nop_cnt2", 32'(retired_count_b), 32'((i + 1) % 4));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
